// File: rtl/hap_pkg.sv
// Shared definitions for the HAP compare datapath.
// Opcode map, sequencer state encoding and opcode legality helper.
package hap_pkg;

  localparam logic [4:0] OP_LT  = 5'b01011;
  localparam logic [4:0] OP_GT  = 5'b01100;
  localparam logic [4:0] OP_EQ  = 5'b01101;
  localparam logic [4:0] OP_GTE = 5'b01110;
  localparam logic [4:0] OP_LTE = 5'b01111;
  localparam logic [4:0] OP_NE  = 5'b10000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  function automatic logic is_cmp_opcode(
    input logic [4:0] op
  );
    return (op >= OP_LT) && (op <= OP_NE);
  endfunction

endpackage

// File: rtl/compare_ctrl_cmp_eval.sv
// Combinational compare evaluator.
// Unsigned compare of a against b; legal flags a recognised opcode.
module cmp_eval
  import hap_pkg::*;
#(
  parameter int DW = 3
) (
  input  logic [4:0]    opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          legal,
  output logic          result
);

  always_comb begin
    legal  = is_cmp_opcode(opcode);
    result = 1'b0;
    case (opcode)
      OP_LT:   result = a <  b;
      OP_GT:   result = a >  b;
      OP_EQ:   result = a == b;
      OP_GTE:  result = a >= b;
      OP_LTE:  result = a <= b;
      OP_NE:   result = a != b;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/compare_ctrl.sv
// Compare sequencer: accept, read sources, evaluate, write back.
// Every output is a flop so strobes are clean single-cycle pulses.
module compare_ctrl
  import hap_pkg::*;
#(
  parameter int DW = 3,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [4:0]    opcode,
  input  logic [AW-1:0] rd_idx,
  input  logic [AW-1:0] rs1_idx,
  input  logic [AW-1:0] rs2_idx,
  output logic          rf_re,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          done,
  output logic          err,
  output logic          cmp_flag
);

  logic [1:0]    state;
  logic [4:0]    op_q;
  logic [AW-1:0] rd_q;
  logic          res_q;
  logic          legal_q;
  logic          ev_legal;
  logic          ev_result;

  cmp_eval #(
    .DW(DW)
  ) u_eval (
    .opcode(op_q),
    .a     (rf_rdata1),
    .b     (rf_rdata2),
    .legal (ev_legal),
    .result(ev_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      op_q        <= '0;
      rd_q        <= '0;
      res_q       <= 1'b0;
      legal_q     <= 1'b0;
      rf_re       <= 1'b0;
      rf_raddr1   <= '0;
      rf_raddr2   <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      cmp_flag    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q        <= opcode;
            rd_q        <= rd_idx;
            rf_re       <= 1'b1;
            rf_raddr1   <= rs1_idx;
            rf_raddr2   <= rs2_idx;
            instr_ready <= 1'b0;
            state       <= S_READ;
          end
        end
        S_READ: begin
          rf_re     <= 1'b0;
          rf_raddr1 <= '0;
          rf_raddr2 <= '0;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          res_q   <= ev_result;
          legal_q <= ev_legal;
          done    <= 1'b1;
          err     <= ~ev_legal;
          if (ev_legal) begin
            rf_we    <= 1'b1;
            rf_waddr <= rd_q;
            rf_wdata <= {{(DW-1){1'b0}}, ev_result};
          end
          state <= S_WB;
        end
        S_WB: begin
          rf_we    <= 1'b0;
          rf_waddr <= '0;
          rf_wdata <= '0;
          done     <= 1'b0;
          err      <= 1'b0;
          if (legal_q)
            cmp_flag <= res_q;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_ctrl.sv
// Directed bench for compare_ctrl with a small register-file model.
// Vector table for single instructions, hand sequences for corners.
module tb_compare_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [4:0] opcode = '0;
  logic [2:0] rd_idx = '0;
  logic [2:0] rs1_idx = '0;
  logic [2:0] rs2_idx = '0;
  logic       rf_re;
  logic [2:0] rf_raddr1;
  logic [2:0] rf_raddr2;
  logic [2:0] rf_rdata1 = '0;
  logic [2:0] rf_rdata2 = '0;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [2:0] rf_wdata;
  logic       done;
  logic       err;
  logic       cmp_flag;

  logic [2:0] regs [8];

  int checks = 0;
  int errors = 0;

  compare_ctrl #(
    .DW(3),
    .AW(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode     (opcode),
    .rd_idx     (rd_idx),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rf_re      (rf_re),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .done       (done),
    .err        (err),
    .cmp_flag   (cmp_flag)
  );

  always #5 clk = ~clk;

  // read data appears the cycle after the strobe
  always @(posedge clk) begin
    if (rf_re) begin
      rf_rdata1 <= regs[rf_raddr1];
      rf_rdata2 <= regs[rf_raddr2];
    end
  end

  typedef struct {
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       bad;
    logic       res;
    logic       flag;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [2:0] rd,
                              input logic [2:0] rs1, input logic [2:0] rs2,
                              input logic bad, input logic res,
                              input logic flag);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.bad = bad; v.res = res; v.flag = flag;
    return v;
  endfunction

  task automatic run(input vec_t v);
    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    opcode = v.op; rd_idx = v.rd; rs1_idx = v.rs1; rs2_idx = v.rs2;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("re_n1", rf_re, 1);
    chk("raddr1", rf_raddr1, v.rs1);
    chk("raddr2", rf_raddr2, v.rs2);
    chk("ready_n1", instr_ready, 0);
    @(negedge clk);
    chk("re_n2", rf_re, 0);
    chk("quiet_n2", {rf_we, done, err, rf_raddr1}, 0);
    @(negedge clk);
    chk("we_n3", rf_we, !v.bad);
    chk("done_n3", done, 1);
    chk("err_n3", err, v.bad);
    chk("waddr", rf_waddr, v.bad ? 3'd0 : v.rd);
    chk("wdata", rf_wdata, v.bad ? 3'd0 : {2'b00, v.res});
    @(negedge clk);
    chk("done_n4", {rf_we, done, err}, 0);
    chk("flag", cmp_flag, v.flag);
  endtask

  initial begin
    regs[0] = 3'd0; regs[1] = 3'd2; regs[2] = 3'd5; regs[3] = 3'd1;
    regs[4] = 3'd4; regs[5] = 3'd4; regs[6] = 3'd4; regs[7] = 3'd7;

    tbl[0]  = mk(5'b01011, 3'd3, 3'd1, 3'd2, 0, 1, 1);
    tbl[1]  = mk(5'b01011, 3'd3, 3'd4, 3'd5, 0, 0, 0);
    tbl[2]  = mk(5'b01100, 3'd3, 3'd4, 3'd5, 0, 0, 0);
    tbl[3]  = mk(5'b01101, 3'd3, 3'd4, 3'd5, 0, 1, 1);
    tbl[4]  = mk(5'b01110, 3'd3, 3'd4, 3'd5, 0, 1, 1);
    tbl[5]  = mk(5'b01111, 3'd3, 3'd4, 3'd5, 0, 1, 1);
    tbl[6]  = mk(5'b10000, 3'd3, 3'd4, 3'd5, 0, 0, 0);
    tbl[7]  = mk(5'b01101, 3'd3, 3'd4, 3'd6, 0, 1, 1);
    tbl[8]  = mk(5'b00000, 3'd3, 3'd4, 3'd5, 1, 0, 1);
    tbl[9]  = mk(5'b01100, 3'd2, 3'd2, 3'd1, 0, 1, 1);
    tbl[10] = mk(5'b01111, 3'd1, 3'd2, 3'd1, 0, 0, 0);
    tbl[11] = mk(5'b01011, 3'd7, 3'd0, 3'd7, 0, 1, 1);
    tbl[12] = mk(5'b10001, 3'd6, 3'd6, 3'd6, 1, 0, 1);

    // reset for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_strobes", {rf_re, rf_we, done, err}, 0);
    chk("rst_addr", {rf_raddr1, rf_raddr2, rf_waddr, rf_wdata}, 0);
    chk("rst_flag", cmp_flag, 0);

    for (int i = 0; i < 13; i++)
      run(tbl[i]);

    // back-to-back: valid held, accept every fourth cycle
    @(negedge clk);
    instr_valid = 1'b1;
    opcode = 5'b01011; rd_idx = 3'd4; rs1_idx = 3'd0; rs2_idx = 3'd7;
    for (int i = 0; i < 12; i++) begin
      chk("b2b_ready", instr_ready, (i % 4) == 0);
      chk("b2b_re", rf_re, (i % 4) == 1);
      chk("b2b_done", done, (i % 4) == 3);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("b2b_end_ready", instr_ready, 1);

    // reset during EXEC drops the instruction and clears the flag
    chk("pre_rst_flag", cmp_flag, 1);
    instr_valid = 1'b1;
    opcode = 5'b01101; rd_idx = 3'd5; rs1_idx = 3'd4; rs2_idx = 3'd5;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("exec_rst_re", rf_re, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("exec_rst_ready", instr_ready, 1);
    chk("exec_rst_quiet", {rf_re, rf_we, done, err}, 0);
    chk("exec_rst_flag", cmp_flag, 0);
    @(negedge clk);
    chk("exec_rst_after", {rf_re, rf_we, done, err}, 0);

    // reset coincident with valid: not accepted
    rst = 1'b1;
    instr_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
    chk("rst_valid_ready", instr_ready, 1);
    chk("rst_valid_re", rf_re, 0);
    @(negedge clk);
    chk("rst_valid_quiet", {rf_re, rf_we, done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
